register_file_mp: RTL and testbench

- Parametrised multi-port general-purpose register file for the next-generation 8-bit core datapath; generalises the current 16x8 single-write register file.
- Provides two combinational read ports, two write ports with fixed priority, and optional write-to-read bypass.
- Optional hardwired zero register.
- Per-register busy scoreboard so the control unit can stall on registers with an outstanding load.

---
 rtl/register_file_mp.sv | 140 ++++++++++++++
 tb/tb_register_file_mp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file: two combinational read ports, two prioritised write ports
// (port 1 wins), optional write-to-read bypass, optional hardwired zero register, busy scoreboard.

module register_file_mp_cell #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic              sb_set_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;

    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        if (we1_i)      data_d = wd1_i;
        else if (we0_i) data_d = wd0_i;
        // A load issued in the same cycle as a write keeps the register busy.
        if (we0_i || we1_i) busy_d = 1'b0;
        if (sb_set_i)       busy_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;
endmodule

module register_file_mp #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 16,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 0,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic              busy_any
);
    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] reg_q;
    logic [NUM_REGS-1:0]             busy_q;
    logic [NUM_REGS-1:0]             we0_hit, we1_hit, sb_hit;
    logic [1:0][ADDR_W-1:0]          rd_addr;
    logic [1:0][DATA_W-1:0]          rd_data;
    logic [1:0]                      rd_busy;

    // True for addresses backed by a writable register (in range, not the zero register).
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_W) && !(ZERO_REG != 0 && a == '0);
    endfunction

    always_comb begin
        we0_hit = '0;
        we1_hit = '0;
        sb_hit  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!(ZERO_REG != 0 && i == 0)) begin
                we0_hit[i] = wr0_en    && (wr0_addr    == ADDR_W'(i));
                we1_hit[i] = wr1_en    && (wr1_addr    == ADDR_W'(i));
                sb_hit[i]  = sb_set_en && (sb_set_addr == ADDR_W'(i));
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        register_file_mp_cell #(.DATA_W(DATA_W)) u_cell (
            .clk_i    (clk),
            .rst_ni   (reset),
            .we0_i    (we0_hit[g]),
            .we1_i    (we1_hit[g]),
            .wd0_i    (wr0_data),
            .wd1_i    (wr1_data),
            .sb_set_i (sb_hit[g]),
            .data_o   (reg_q[g]),
            .busy_o   (busy_q[g])
        );
    end

    assign rd_addr = {rd_addr_b, rd_addr_a};

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr[p] == ADDR_W'(i)) begin
                    rd_data[p] = reg_q[i];
                    rd_busy[p] = busy_q[i];
                end
            end
            // Forwarded data is the value being produced, so it is never busy.
            if (BYPASS != 0 && addr_live(rd_addr[p])) begin
                if (wr1_en && wr1_addr == rd_addr[p]) begin
                    rd_data[p] = wr1_data;
                    rd_busy[p] = 1'b0;
                end else if (wr0_en && wr0_addr == rd_addr[p]) begin
                    rd_data[p] = wr0_data;
                    rd_busy[p] = 1'b0;
                end
            end
        end
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];
    assign rd_busy_a = rd_busy[0];
    assign rd_busy_b = rd_busy[1];
    assign busy_any  = |busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: four instances (default, no-bypass, zero-reg, 12 regs)
// share one stimulus stream; each check compares against hand-computed values.

module tb_register_file_mp;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rd_addr_a, rd_addr_b, wr0_addr, wr1_addr, sb_set_addr;
    logic [7:0] wr0_data, wr1_data;
    logic       wr0_en, wr1_en, sb_set_en;

    logic [7:0] d_rda, d_rdb, n_rda, n_rdb, z_rda, z_rdb, t_rda, t_rdb;
    logic       d_ba, d_bb, d_any, n_ba, n_bb, n_any, z_ba, z_bb, z_any, t_ba, t_bb, t_any;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_file_mp #(.DATA_W(8), .NUM_REGS(16), .BYPASS(1), .ZERO_REG(0)) u_def (
        .clk(clk), .reset(reset), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(d_rda), .rd_data_b(d_rdb), .rd_busy_a(d_ba), .rd_busy_b(d_bb),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_any(d_any));

    register_file_mp #(.DATA_W(8), .NUM_REGS(16), .BYPASS(0), .ZERO_REG(0)) u_nb (
        .clk(clk), .reset(reset), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(n_rda), .rd_data_b(n_rdb), .rd_busy_a(n_ba), .rd_busy_b(n_bb),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_any(n_any));

    register_file_mp #(.DATA_W(8), .NUM_REGS(16), .BYPASS(1), .ZERO_REG(1)) u_zr (
        .clk(clk), .reset(reset), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(z_rda), .rd_data_b(z_rdb), .rd_busy_a(z_ba), .rd_busy_b(z_bb),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_any(z_any));

    register_file_mp #(.DATA_W(8), .NUM_REGS(12), .BYPASS(1), .ZERO_REG(0)) u_r12 (
        .clk(clk), .reset(reset), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(t_rda), .rd_data_b(t_rdb), .rd_busy_a(t_ba), .rd_busy_b(t_bb),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_any(t_any));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0;
    endtask

    task automatic wr0(input logic [3:0] a, input logic [7:0] d);
        wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
    endtask

    task automatic wr1(input logic [3:0] a, input logic [7:0] d);
        wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
    endtask

    task automatic sbset(input logic [3:0] a);
        sb_set_en = 1'b1; sb_set_addr = a;
    endtask

    // One clock edge, then drop all enables so post-edge checks see stored state.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        rd_addr_a = '0;
        rd_addr_b = '0;
        #3;
        chk("rst_data", d_rda, 8'h00);
        chk("rst_busy", d_ba, 1'b0);
        chk("rst_any", d_any, 1'b0);
        #1 reset = 1'b1;

        // Write then mid-cycle asynchronous reset.
        wr0(4'd3, 8'hA5); sbset(4'd9);
        cyc();
        rd_addr_a = 4'd3;
        #1;
        chk("wr_r3", d_rda, 8'hA5);
        chk("any_r9", d_any, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("arst_data", d_rda, 8'h00);
        chk("arst_any", d_any, 1'b0);
        #1 reset = 1'b1;

        // Dual-write collision and independent dual writes.
        wr0(4'd5, 8'h11); wr1(4'd5, 8'h22);
        cyc();
        wr0(4'd6, 8'h33); wr1(4'd7, 8'h44);
        cyc();
        rd_addr_a = 4'd5; rd_addr_b = 4'd6;
        #1;
        chk("coll_r5", d_rda, 8'h22);
        chk("dual_r6", d_rdb, 8'h33);
        rd_addr_a = 4'd7;
        #1;
        chk("dual_r7", d_rda, 8'h44);

        // Bypass vs. stored-only read.
        wr0(4'd2, 8'h10);
        cyc();
        wr0(4'd2, 8'h7F); rd_addr_a = 4'd2;
        #1;
        chk("byp_on", d_rda, 8'h7F);
        chk("byp_off", n_rda, 8'h10);
        cyc();
        #1;
        chk("byp_off_next", n_rda, 8'h7F);
        wr0(4'd8, 8'h01); wr1(4'd8, 8'h02); rd_addr_b = 4'd8;
        #1;
        chk("byp_prio", d_rdb, 8'h02);
        chk("byp_prio_off", n_rdb, 8'h00);
        cyc();

        // Hardwired zero register.
        wr0(4'd0, 8'hFF); sbset(4'd0); rd_addr_a = 4'd0;
        #1;
        chk("zr_byp", z_rda, 8'h00);
        chk("zr_busy_byp", z_ba, 1'b0);
        chk("r0_byp", d_rda, 8'hFF);
        chk("r0_busy_byp", d_ba, 1'b0);
        cyc();
        #1;
        chk("zr_data", z_rda, 8'h00);
        chk("zr_busy", z_ba, 1'b0);
        chk("zr_any", z_any, 1'b0);
        chk("r0_data", d_rda, 8'hFF);
        chk("r0_setwins", d_ba, 1'b1);
        wr0(4'd0, 8'h00);
        cyc();

        // Scoreboard set / clear / set-wins.
        sbset(4'd4);
        cyc();
        rd_addr_b = 4'd4;
        #1;
        chk("sb_busy", d_bb, 1'b1);
        chk("sb_any", d_any, 1'b1);
        wr1(4'd4, 8'h9C);
        #1;
        chk("sb_byp_clr", d_bb, 1'b0);
        chk("sb_nobyp", n_bb, 1'b1);
        chk("sb_byp_data", d_rdb, 8'h9C);
        cyc();
        #1;
        chk("sb_clr_any", d_any, 1'b0);
        chk("sb_r4", d_rdb, 8'h9C);
        sbset(4'd4); wr0(4'd4, 8'h01);
        cyc();
        #1;
        chk("sb_setwins", d_bb, 1'b1);
        chk("sb_setwins_any", d_any, 1'b1);
        chk("sb_setwins_data", d_rdb, 8'h01);
        wr0(4'd4, 8'h00);
        cyc();
        #1;
        chk("sb_final_any", d_any, 1'b0);

        // Non-power-of-two register count.
        for (int i = 0; i < 12; i++) begin
            wr0(4'(i), 8'(8'h30 + i));
            cyc();
        end
        wr0(4'd13, 8'h55); wr1(4'd12, 8'h66); sbset(4'd13);
        rd_addr_a = 4'd13; rd_addr_b = 4'd12;
        #1;
        chk("r12_oor_byp_a", t_rda, 8'h00);
        chk("r12_oor_byp_b", t_rdb, 8'h00);
        chk("r16_byp_13", d_rda, 8'h55);
        cyc();
        #1;
        chk("r12_oor_a", t_rda, 8'h00);
        chk("r12_oor_b", t_rdb, 8'h00);
        chk("r12_oor_any", t_any, 1'b0);
        chk("r16_r13", d_rda, 8'h55);
        chk("r16_r13_any", d_any, 1'b1);
        for (int i = 0; i < 12; i++) begin
            rd_addr_a = 4'(i);
            #1;
            chk($sformatf("r12_keep%0d", i), t_rda, 32'(8'h30 + i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
